// File: rtl/lns_encoder_if.sv
// lns_encoder_if: operand-in / LNS-word-out valid/ready handshakes of the encoder
interface lns_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/lns_encoder.sv
// lns_encoder: int16 to LNS (sign + Q7.8 log2) via leading-one normalise and repeated squaring
module lns_encoder #(
  parameter int FRAC_BITS = 8
) (
  input  logic           clk,
  input  logic           reset,
  lns_encoder_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, NORM, FRAC, DONE} state_t;
  state_t      state_q;
  logic        sign_q, zero_q;
  logic [15:0] mag_q, m_q, out_data_q;
  logic [3:0]  e_q, e_d;
  logic [7:0]  frac_q, frac_d;
  logic [2:0]  cnt_q;
  logic [31:0] sq_d;
  always_comb begin
    e_d = '0;
    for (int i = 0; i < 16; i++) if (mag_q[i]) e_d = 4'(i);
  end
  assign sq_d   = {16'b0, m_q} * {16'b0, m_q};
  assign frac_d = {frac_q[6:0], sq_d[31]};
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.out_data  = out_data_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      out_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          sign_q  <= bus.in_data[15];
          mag_q   <= bus.in_data[15] ? 16'(-bus.in_data) : bus.in_data;
          zero_q  <= bus.in_data == '0;
          state_q <= NORM;
        end
        NORM: begin
          e_q     <= e_d;
          m_q     <= mag_q << (4'd15 - e_d);
          frac_q  <= '0;
          cnt_q   <= '0;
          state_q <= FRAC;
        end
        FRAC: begin
          frac_q <= frac_d;
          m_q    <= sq_d[31] ? sq_d[31:16] : sq_d[30:15];
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'(FRAC_BITS - 1)) begin
            out_data_q <= zero_q ? 16'h4000 : {sign_q, 3'b000, e_q, frac_d};
            state_q    <= DONE;
          end
        end
        default: if (bus.out_ready) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lns_encoder.sv
// tb_lns_encoder: scoreboard bench with directed spec vectors and a randomized reference-model phase
module tb_lns_encoder;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  lns_encoder_if bus();
  lns_encoder dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] exp_q[$];
  int lat_q[$];
  logic prev_v = 0;
  bit rand_rdy = 0, rdy_val = 1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2 bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask
  // Reference: floor(log2) by shifting, fraction by integer repeated squaring of the normalised mantissa
  function automatic logic [15:0] model(input logic [15:0] x);
    longint v, mag, m, sq;
    int e, frac;
    v = longint'($signed(x));
    if (v == 0) return 16'h4000;
    mag = v < 0 ? -v : v;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    m = mag;
    while (m < 32768) m = m * 2;
    frac = 0;
    for (int k = 0; k < 8; k++) begin
      sq = m * m;
      if (sq >= (longint'(1) << 31)) begin
        frac = frac * 2 + 1;
        m = sq / 65536;
      end else begin
        frac = frac * 2;
        m = sq / 32768;
      end
    end
    return {v < 0, 3'b000, 4'(e), 8'(frac)};
  endfunction
  always @(negedge clk) begin
    if (reset) prev_v = 0;
    else begin
      if (bus.out_valid && !prev_v) begin
        if (lat_q.size() == 0) flag("unexpected out_valid");
        else check("latency", cyc, lat_q.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) flag("unexpected result");
        else check("out_data", {16'b0, bus.out_data}, {16'b0, exp_q.pop_front()});
      end
      prev_v = bus.out_valid;
    end
  end
  task automatic send(input logic [15:0] d, input logic [15:0] e);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 200) begin
      flag("timeout waiting for in_ready");
      return;
    end
    bus.in_valid = 1;
    bus.in_data = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1 lat_q.push_back(cyc + 9);
    bus.in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) flag("timeout waiting for results");
  endtask
  initial begin
    int n;
    logic [15:0] d;
    bus.in_valid = 0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("reset in_ready", 32'(bus.in_ready), 1);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset out_data", 32'(bus.out_data), 0);
    send(16'h0001, 16'h0000);
    repeat (9) begin
      check("in_ready low while busy", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    check("in_ready low in DONE", 32'(bus.in_ready), 0);
    send(16'h0002, 16'h0100);
    send(16'hFFFC, 16'h8200);
    send(16'h8000, 16'h8F00);
    send(16'h4000, 16'h0E00);
    send(16'h0003, 16'h0195);
    send(16'hFFFD, 16'h8195);
    send(16'h7FFF, 16'h0EFF);
    send(16'h0000, 16'h4000);
    drain();
    rdy_val = 0;
    send(16'h0003, 16'h0195);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.in_data = 16'h0005;
      check("hold out_valid", 32'(bus.out_valid), 1);
      check("hold out_data", 32'(bus.out_data), 32'h0195);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 0;
    rdy_val = 1;
    drain();
    @(posedge clk);
    #1 check("in_ready after handshake", 32'(bus.in_ready), 1);
    check("out_valid after handshake", 32'(bus.out_valid), 0);
    send(16'h0007, model(16'h0007));
    drain();
    send(16'h1234, model(16'h1234));
    repeat (4) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 exp_q.delete();
    lat_q.delete();
    check("midreset in_ready", 32'(bus.in_ready), 1);
    check("midreset out_valid", 32'(bus.out_valid), 0);
    check("midreset busy", 32'(bus.busy), 0);
    check("midreset out_data", 32'(bus.out_data), 0);
    reset = 0;
    repeat (15) @(posedge clk);
    #1 send(16'h0002, 16'h0100);
    drain();
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 7))
        0: d = 16'h0000;
        1: d = 16'h8000;
        2: d = 16'(1 << $urandom_range(0, 14));
        default: ;
      endcase
      send(d, model(d));
    end
    drain();
    rand_rdy = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
